// File: rtl/lsu_arb.sv
// rtl/lsu_arb.sv - core/dbg fixed-priority arbiter for the shared LSU with starvation guard
module lsu_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_bmask_i,
    input  logic        core_us_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [3:0]  dbg_bmask_i,
    input  logic        dbg_us_i,
    output logic        core_gnt_o,
    output logic        dbg_gnt_o,
    output logic        core_rvalid_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic [31:0] dbg_rdata_o,
    output logic        core_err_o,
    output logic        dbg_err_o,
    output logic        lsu_sten_o,
    output logic [31:0] lsu_addr_o,
    output logic [31:0] lsu_st_data_o,
    output logic [3:0]  lsu_byte_num_o,
    output logic        lsu_ld_us_o,
    input  logic [31:0] lsu_ld_data_i
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        core_rvalid_q, core_rvalid_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        core_err_q, core_err_d;
    logic        dbg_err_q, dbg_err_d;

    logic        starved;
    logic        sel_we;
    logic [3:0]  sel_mask;
    logic        sel_legal;
    logic        any_gnt;

    function automatic logic mask_legal(input logic [3:0] m);
        return (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1111);
    endfunction

    always_comb begin
        starved    = dbg_req_i && (wait_cnt_q == MAX_W);
        core_gnt_o = rst_ni && core_req_i && !starved;
        dbg_gnt_o  = rst_ni && dbg_req_i && (!core_req_i || starved);
        any_gnt    = core_gnt_o || dbg_gnt_o;

        // Idle cycles present the core fields; sten stays low so nothing commits.
        sel_we         = dbg_gnt_o ? dbg_we_i     : core_we_i;
        sel_mask       = dbg_gnt_o ? dbg_bmask_i  : core_bmask_i;
        lsu_addr_o     = dbg_gnt_o ? dbg_addr_i   : core_addr_i;
        lsu_st_data_o  = dbg_gnt_o ? dbg_wdata_i  : core_wdata_i;
        lsu_ld_us_o    = dbg_gnt_o ? dbg_us_i     : core_us_i;
        lsu_byte_num_o = sel_mask;
        sel_legal      = mask_legal(sel_mask);
        lsu_sten_o     = any_gnt && sel_we && sel_legal;
    end

    always_comb begin
        wait_cnt_d = 4'd0;
        if (dbg_req_i && !dbg_gnt_o) begin
            wait_cnt_d = (wait_cnt_q >= MAX_W) ? MAX_W : wait_cnt_q + 4'd1;
        end

        core_rvalid_d = core_gnt_o;
        dbg_rvalid_d  = dbg_gnt_o;
        core_err_d    = core_gnt_o && !sel_legal;
        dbg_err_d     = dbg_gnt_o && !sel_legal;
        core_rdata_d  = (core_gnt_o && !sel_we && sel_legal) ? lsu_ld_data_i : 32'd0;
        dbg_rdata_d   = (dbg_gnt_o && !sel_we && sel_legal) ? lsu_ld_data_i : 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q    <= 4'd0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= 32'd0;
            dbg_rdata_q   <= 32'd0;
            core_err_q    <= 1'b0;
            dbg_err_q     <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
            core_err_q    <= core_err_d;
            dbg_err_q     <= dbg_err_d;
        end
    end

    // A response still in flight when reset arrives is dropped, not shown.
    assign core_rvalid_o = core_rvalid_q && rst_ni;
    assign dbg_rvalid_o  = dbg_rvalid_q && rst_ni;
    assign core_err_o    = core_err_q && core_rvalid_o;
    assign dbg_err_o     = dbg_err_q && dbg_rvalid_o;
    assign core_rdata_o  = core_rdata_q;
    assign dbg_rdata_o   = dbg_rdata_q;

endmodule

// File: tb/tb_lsu_arb.sv
// tb/tb_lsu_arb.sv - directed-vector bench for lsu_arb with a small word-memory LSU model
module tb_lsu_arb;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        core_req, core_we, core_us;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_bmask;
    logic        dbg_req, dbg_we, dbg_us;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [3:0]  dbg_bmask;
    logic        core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_err, dbg_err;
    logic [31:0] core_rdata, dbg_rdata;
    logic        lsu_sten, lsu_us;
    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
    logic [3:0]  lsu_byte_num;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsu_arb #(.MAX_WAIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_bmask_i(core_bmask), .core_us_i(core_us),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_bmask_i(dbg_bmask), .dbg_us_i(dbg_us),
        .core_gnt_o(core_gnt), .dbg_gnt_o(dbg_gnt),
        .core_rvalid_o(core_rvalid), .dbg_rvalid_o(dbg_rvalid),
        .core_rdata_o(core_rdata), .dbg_rdata_o(dbg_rdata),
        .core_err_o(core_err), .dbg_err_o(dbg_err),
        .lsu_sten_o(lsu_sten), .lsu_addr_o(lsu_addr), .lsu_st_data_o(lsu_st_data),
        .lsu_byte_num_o(lsu_byte_num), .lsu_ld_us_o(lsu_us), .lsu_ld_data_i(lsu_ld_data)
    );

    // LSU model: unwritten words read back as their word index.
    logic [31:0] mem     [0:1023];
    logic        written [0:1023];

    function automatic logic [31:0] rd_word(input logic [9:0] idx);
        return written[idx] ? mem[idx] : {22'd0, idx};
    endfunction

    assign lsu_ld_data = rd_word(lsu_addr[11:2]);

    always @(posedge clk) begin
        if (lsu_sten) begin
            logic [31:0] w;
            w = rd_word(lsu_addr[11:2]);
            for (int b = 0; b < 4; b++)
                if (lsu_byte_num[b]) w[8*b +: 8] = lsu_st_data[8*b +: 8];
            mem[lsu_addr[11:2]]     <= w;
            written[lsu_addr[11:2]] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask);
        core_req = req; core_we = we; core_addr = addr; core_wdata = wdata; core_bmask = mask;
        core_us = 1'b0;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask);
        dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_bmask = mask;
        dbg_us = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) written[i] = 1'b0;
        rst_ni = 1'b0;
        drive_core(1'b1, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
        drive_dbg(1'b1, 1'b1, 32'h20, 32'h2222_2222, 4'hF);

        // Reset with both ports requesting stores
        #2;
        check("rst0_core_gnt", core_gnt, 0);
        check("rst0_dbg_gnt", dbg_gnt, 0);
        check("rst0_sten", lsu_sten, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_core_gnt", core_gnt, 0);
            check("rst_dbg_gnt", dbg_gnt, 0);
            check("rst_sten", lsu_sten, 0);
            check("rst_core_rvalid", core_rvalid, 0);
            check("rst_dbg_rvalid", dbg_rvalid, 0);
            check("rst_core_rdata", core_rdata, 0);
            check("rst_dbg_rdata", dbg_rdata, 0);
            check("rst_wait_cnt", dut.wait_cnt_q, 0);
        end
        rst_ni = 1'b1;
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        #1;
        check("idle_core_gnt", core_gnt, 0);
        check("idle_dbg_gnt", dbg_gnt, 0);
        tick();
        check("idle_core_rvalid", core_rvalid, 0);
        check("idle_dbg_rvalid", dbg_rvalid, 0);

        // Core store then load of 0x010
        drive_core(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("st_core_gnt", core_gnt, 1);
        check("st_sten", lsu_sten, 1);
        check("st_addr", lsu_addr, 32'h10);
        tick();
        drive_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        check("ld_core_gnt", core_gnt, 1);
        check("ld_sten", lsu_sten, 0);
        check("st_ack_rvalid", core_rvalid, 1);
        check("st_ack_rdata", core_rdata, 0);
        tick();
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        check("ld_rvalid", core_rvalid, 1);
        check("ld_rdata", core_rdata, 32'hDEAD_BEEF);
        check("ld_err", core_err, 0);
        tick();
        check("ld_rvalid_pulse", core_rvalid, 0);

        // Starvation guard: dbg wins in cycle 4
        drive_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        drive_dbg(1'b1, 1'b0, 32'h880, 32'h0, 4'hF);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("starve_wait_cnt", dut.wait_cnt_q, c);
            check("starve_dbg_gnt", dbg_gnt, (c == 4) ? 1 : 0);
            check("starve_core_gnt", core_gnt, (c == 4) ? 0 : 1);
            tick();
        end
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        check("starve_cnt_clear", dut.wait_cnt_q, 0);
        check("starve_dbg_rvalid", dbg_rvalid, 1);
        check("starve_dbg_rdata", dbg_rdata, 32'h0000_0220);
        check("starve_core_rvalid", core_rvalid, 0);
        tick();

        // Simultaneous request with counter at 0
        drive_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        drive_dbg(1'b1, 1'b0, 32'h880, 32'h0, 4'hF);
        #1;
        check("sim_core_gnt", core_gnt, 1);
        check("sim_dbg_gnt", dbg_gnt, 0);
        tick();
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        #1;
        check("sim_dbg_gnt2", dbg_gnt, 1);
        check("sim_core_rvalid1", core_rvalid, 1);
        check("sim_dbg_rvalid1", dbg_rvalid, 0);
        tick();
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        check("sim_core_rvalid2", core_rvalid, 0);
        check("sim_dbg_rvalid2", dbg_rvalid, 1);
        check("sim_dbg_rdata", dbg_rdata, 32'h0000_0220);
        tick();
        check("sim_dbg_rvalid3", dbg_rvalid, 0);

        // Illegal mask store by dbg
        drive_dbg(1'b1, 1'b1, 32'h880, 32'hFFFF_FFFF, 4'b0101);
        #1;
        check("ill_dbg_gnt", dbg_gnt, 1);
        check("ill_sten", lsu_sten, 0);
        tick();
        drive_dbg(1'b1, 1'b0, 32'h880, 32'h0, 4'hF);
        #1;
        check("ill_rvalid", dbg_rvalid, 1);
        check("ill_err", dbg_err, 1);
        check("ill_rdata", dbg_rdata, 0);
        check("ill_ld_gnt", dbg_gnt, 1);
        tick();
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        check("ill_ld_rvalid", dbg_rvalid, 1);
        check("ill_ld_err", dbg_err, 0);
        check("ill_ld_rdata", dbg_rdata, 32'h0000_0220);
        tick();

        // Reset the cycle after a core load grant, with a store presented
        drive_core(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        check("rmid_core_gnt", core_gnt, 1);
        tick();
        rst_ni = 1'b0;
        drive_core(1'b1, 1'b1, 32'h10, 32'h5555_5555, 4'hF);
        #1;
        check("rmid_gnt", core_gnt, 0);
        check("rmid_sten", lsu_sten, 0);
        check("rmid_rvalid", core_rvalid, 0);
        tick();
        check("rmid_rvalid2", core_rvalid, 0);
        rst_ni = 1'b1;
        drive_core(1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        tick();
        check("rmid_rvalid3", core_rvalid, 0);
        check("rmid_mem_kept", rd_word(10'd4), 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
